// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer
package fetch_pkg;
   localparam int FETCH_AW = 9;
   localparam int FETCH_IW = 32;
   localparam int PC_STEP = 4;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;
   typedef struct packed {
      logic [FETCH_AW-1:0] pc;
      logic [FETCH_IW-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/imem_fetch_sequencer_fifo.sv
// fetch_skid_fifo: 2-entry FIFO with same-cycle push/pop at any occupancy and flush
module fetch_skid_fifo #(
   parameter int W = 41
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] e0, e1;
   // e0 is always the head; e1 only holds the second entry when two are queued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         e0 <= '0;
         e1 <= '0;
      end else begin
         count <= flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
         if (pop || count == 2'd0) e0 <= (pop && count == 2'd2) ? e1 : din;
         if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) e1 <= din;
      end
   end
   assign head = e0;
   assign full = count == 2'd2;
   assign empty = count == 2'd0;
endmodule

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: PC owner and fetch FSM feeding decode through a skid FIFO
module imem_fetch_sequencer import fetch_pkg::*; #(
   parameter int INS_ADDRESS = FETCH_AW,
   parameter int INS_W = FETCH_IW,
   parameter logic [INS_ADDRESS-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   output logic [INS_ADDRESS-1:0] imem_ra,
   input  logic [INS_W-1:0]       imem_rd,
   input  logic                   redir_valid,
   input  logic [INS_ADDRESS-1:0] redir_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INS_W-1:0]       out_inst,
   output logic [INS_ADDRESS-1:0] out_pc,
   output logic                   busy
);
   localparam logic [INS_ADDRESS-1:0] PC0 = {RESET_PC[INS_ADDRESS-1:2], 2'b00};
   localparam logic [INS_ADDRESS-1:0] STEP = INS_ADDRESS'(PC_STEP);
   fetch_state_t state, state_nx;
   logic [INS_ADDRESS-1:0] pc, pc_nx;
   logic [INS_ADDRESS+INS_W-1:0] head;
   logic [1:0] count;
   logic full, empty, pop, redir, fetch_en;
   assign redir = redir_valid && state != IDLE;
   assign pop = out_valid && out_ready;
   // a full FIFO can still take a fetch when its head leaves the same cycle
   assign fetch_en = state == RUN && !redir_valid && !stop && (!full || out_ready);
   // redirect beats stop beats fetch; a redirect in DRAIN empties the FIFO so it ends the drain
   always_comb begin
      state_nx = state == IDLE  ? (start ? RUN : IDLE)
               : state == RUN   ? (stop ? DRAIN : RUN)
               : state == DRAIN ? ((redir_valid || count == 2'd0) ? IDLE : DRAIN)
               : IDLE;
      pc_nx = redir ? {redir_pc[INS_ADDRESS-1:2], 2'b00}
            : fetch_en ? pc + STEP
            : (state == IDLE && start) ? PC0
            : pc;
   end
   // state and PC registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= PC0;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
      end
   end
   fetch_skid_fifo #(.W(INS_ADDRESS + INS_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redir),
      .push  (fetch_en),
      .pop   (pop),
      .din   ({pc, imem_rd}),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );
   assign imem_ra = {pc[INS_ADDRESS-1:2], 2'b00};
   assign out_valid = !empty;
   assign out_inst = empty ? '0 : head[INS_W-1:0];
   assign out_pc = empty ? '0 : head[INS_ADDRESS+INS_W-1:INS_W];
   assign busy = state != IDLE;
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: scoreboard bench for the fetch sequencer
module tb_imem_fetch_sequencer;
   logic clk = 0, rst_n = 0, start = 0, stop = 0, redir_valid = 0, out_ready = 0;
   logic [8:0] redir_pc = '0, imem_ra, out_pc;
   logic [31:0] imem_rd, out_inst;
   logic out_valid, busy;
   logic [8:0] exp_q[$];
   int n_cmp = 0, n_bad = 0;

   function automatic logic [31:0] inst_of(input logic [8:0] a);
      return (a == 9'h00C) ? 32'h00308193 : {16'hC0DE, 7'd0, a};
   endfunction

   always #5 clk = ~clk;
   assign imem_rd = inst_of(imem_ra);

   imem_fetch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .imem_ra(imem_ra),
      .imem_rd(imem_rd), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .busy(busy)
   );

   // every accepted instruction must be the next expected PC with its memory word
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n && out_valid && out_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_extra: got pc %h, expected no output", out_pc);
         end else begin
            e = exp_q.pop_front();
            if (out_pc !== e || out_inst !== inst_of(e)) begin
               n_bad++;
               $display("FAIL sb_data: got pc %h inst %h, expected pc %h inst %h", out_pc, out_inst, e, inst_of(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_n(input int n, input int exp_cyc);
      int got = 0, cyc = 0;
      out_ready = 1;
      while (got < n && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (out_valid) got++;
      end
      n_cmp++;
      if (got != n || cyc != exp_cyc) begin
         n_bad++;
         $display("FAIL accept_rate: got %0d items in %0d cycles, expected %0d in %0d", got, cyc, n, exp_cyc);
      end
      tick();
      out_ready = 0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({out_valid, busy, out_inst, out_pc, imem_ra} !== '0) begin
         n_bad++;
         $display("FAIL reset_vals: got v=%b busy=%b inst=%h pc=%h ra=%h, expected all 0", out_valid, busy, out_inst, out_pc, imem_ra);
      end
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_stream();
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h004);
      start = 1;
      tick();
      start = 0;
      out_ready = 1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || imem_ra !== 9'h000) begin
         n_bad++;
         $display("FAIL first_cycle: got v=%b busy=%b ra=%h, expected v=0 busy=1 ra=000", out_valid, busy, imem_ra);
      end
      tick();
      accept_n(2, 2);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_pc !== 9'h008 || out_inst !== inst_of(9'h008)) begin
            n_bad++;
            $display("FAIL bp_hold: got v=%b pc=%h inst=%h, expected v=1 pc=008 inst=%h", out_valid, out_pc, out_inst, inst_of(9'h008));
         end
         if (i == 4) begin
            n_cmp++;
            if (imem_ra !== 9'h010) begin
               n_bad++;
               $display("FAIL bp_ra: got %h, expected 010", imem_ra);
            end
         end
         tick();
      end
      exp_q.push_back(9'h008);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h010);
      accept_n(3, 3);
   endtask

   task automatic redirect_to(input logic [8:0] target, input logic [8:0] exp_ra);
      tick();
      redir_valid = 1;
      redir_pc = target;
      tick();
      redir_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || imem_ra !== exp_ra) begin
         n_bad++;
         $display("FAIL redir_flush: got v=%b ra=%h, expected v=0 ra=%h", out_valid, imem_ra, exp_ra);
      end
      tick();
   endtask

   task automatic test_redirect();
      redirect_to(9'h023, 9'h020);
      exp_q.push_back(9'h020);
      exp_q.push_back(9'h024);
      exp_q.push_back(9'h028);
      accept_n(3, 3);
   endtask

   task automatic test_wrap();
      redirect_to(9'h1FC, 9'h1FC);
      exp_q.push_back(9'h1FC);
      exp_q.push_back(9'h000);
      accept_n(2, 2);
   endtask

   task automatic test_stop();
      int k = 0;
      tick();
      exp_q.push_back(9'h004);
      exp_q.push_back(9'h008);
      stop = 1;
      out_ready = 1;
      tick();
      stop = 0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_busy: got %b, expected 1", busy);
      end
      while (busy === 1'b1 && k < 10) begin
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || imem_ra !== 9'h00C) begin
            n_bad++;
            $display("FAIL stop_idle: got busy=%b v=%b ra=%h, expected busy=0 v=0 ra=00C", busy, out_valid, imem_ra);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_count: got %0d undrained, expected 0", exp_q.size());
      end
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 0;
      start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      #2;
      rst_n = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || imem_ra !== 9'h000 || out_pc !== 9'h000) begin
         n_bad++;
         $display("FAIL async_rst: got v=%b busy=%b ra=%h pc=%h, expected 0 0 000 000", out_valid, busy, imem_ra, out_pc);
      end
      tick();
      rst_n = 1;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst_idle: got v=%b busy=%b, expected 0 0", out_valid, busy);
         end
         tick();
      end
      redir_valid = 1;
      redir_pc = 9'h040;
      tick();
      redir_valid = 0;
      @(negedge clk);
      n_cmp++;
      if (imem_ra !== 9'h000 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_redir: got ra=%h busy=%b, expected ra=000 busy=0", imem_ra, busy);
      end
      tick();
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h004);
      start = 1;
      tick();
      start = 0;
      accept_n(2, 3);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL final_queue: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_stop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
Sequences the combinational instruction memory. It owns the PC, drives the read address, and captures each {pc, instruction} pair into a 2-entry skid FIFO. It presents fetched instructions to decode over a valid/ready handshake. It also handles start/stop control and branch/jump redirects from execute.

Parameters:
INS_ADDRESS, 9, byte-address width of instruction memory (matches the memory's address width)
INS_W, 32, instruction width
RESET_PC, 0, PC loaded at reset and on start; low 2 bits are ignored

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; IDLE -> RUN, PC <= RESET_PC
stop  input  1  pulse; RUN -> DRAIN
imem_ra  output  INS_ADDRESS  read address to instruction memory
imem_rd  input  INS_W  read data from instruction memory, same-cycle combinational
redir_valid  input  1  redirect request from execute
redir_pc  input  INS_ADDRESS  redirect target; bits [1:0] are forced to 0
out_valid  output  1  fetched instruction available
out_ready  input  1  decode accepts this cycle
out_inst  output  INS_W  instruction at FIFO head
out_pc  output  INS_ADDRESS  PC of out_inst
busy  output  1  state != IDLE

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clk, rst_n.
- Reset values:
  - state = IDLE, pc = RESET_PC with [1:0] = 0, FIFO empty.
  - out_valid = 0, out_inst = 0, out_pc = 0, busy = 0, imem_ra = RESET_PC.
- imem_ra = pc at all times, with bits [1:0] always 0.
- States:
  - IDLE: no fetch. start -> RUN, loading pc = RESET_PC.
  - RUN: fetch enabled. stop -> DRAIN.
  - DRAIN: no fetch. When the FIFO is empty and nothing is accepted that cycle -> IDLE.
- fetch_en = (state == RUN) && !redir_valid && (FIFO not full, or FIFO full and out_ready).
- Fetch: when fetch_en, push {pc, imem_rd} and set pc <= pc + 4.
  - Modulo 2**INS_ADDRESS; wraps from max word to 0 silently.
- Latency:
  - An instruction fetched in cycle N is visible on out_* in cycle N+1.
  - Steady state is 1 instruction/cycle while out_ready = 1.
- FIFO: 2 entries. Pop on out_valid && out_ready. Simultaneous push and pop is legal at any occupancy, including full.
  - out_valid = FIFO not empty.
  - out_inst/out_pc come from the head entry and are held stable while out_valid && !out_ready.
- Redirect (RUN or DRAIN):
  - Flush the FIFO: out_valid = 0 in the next cycle; any entry popped in the redirect cycle still counts as accepted.
  - pc <= redir_pc & ~3; no fetch in the redirect cycle.
  - In DRAIN, a redirect flushes and the block goes to IDLE.
  - Ignored in IDLE.
- Priority within one cycle: redir_valid > stop > fetch.
  - stop with redir_valid in RUN: flush and go to DRAIN; the FIFO is now empty, so IDLE follows next cycle.
- start outside IDLE is ignored. stop outside RUN is ignored.
- Reset mid-operation: everything returns to reset values immediately, asynchronously; the FIFO contents are lost.

Decomposition:
- Shared package fetch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t
  - typedef struct packed {logic [INS_ADDRESS-1:0] pc; logic [INS_W-1:0] inst;} fetch_entry_t
  - localparam PC_STEP = 4
- One sub-module: fetch_skid_fifo, a 2-entry, same-cycle push/pop FIFO with flush, count, full and empty.
- The top level holds the FSM, PC register, and next-PC mux.

Test Plan:
- Reset then start, out_ready = 1 held → out_pc sequence 0x000, 0x004, 0x008…. First out_valid is 1 cycle after RUN entry. out_inst at pc 0x00C = 0x00308193.
- Backpressure: out_ready = 0 for 5 cycles from pc 0x008 → FIFO fills (0x008, 0x00C), imem_ra holds at 0x010, out_* stable. Then out_ready = 1 → 0x008, 0x00C, 0x010 with no gaps or duplicates.
- Redirect redir_pc = 0x023 while FIFO holds 2 entries → next cycle out_valid = 0 and imem_ra = 0x020. Following output is pc 0x020; no pre-redirect PC appears afterward.
- Wrap: redirect to 0x1FC → out_pc 0x1FC, then 0x000.
- stop with 2 entries queued, out_ready = 1 → both drained, then IDLE. busy = 0, imem_ra frozen, no further out_valid.
- Assert rst_n = 0 mid-RUN with a full FIFO → out_valid and busy drop without a clock edge. After release, no output until start.
